// File: rtl/fdivsqrt_r4_iter.sv
// Radix-4 SRT mantissa divider iteration engine (carry-save residual, on-the-fly quotient).
// Latency: done is sampled high ITERS+1 edges after the start edge; early exit on a zero residual
//          when FDIVSQRT_R4_EARLYTERM_EN is defined. No backpressure: start is taken only while ready.
module fdivsqrt_r4_iter #(
  parameter int N     = 52,
  parameter int ITERS = (N + 5) / 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N-1:0]         XFrac,
  input  logic [N-1:0]         DFrac,
  output logic                 ready,
  output logic                 done,
  output logic [2*ITERS-1:0]   Quot,
  output logic                 RemNeg,
  output logic                 Sticky
);

  // Residual: 4 integer bits, N+2 fraction bits, two's complement.
  localparam int WW = N + 6;
  localparam int QW = 2 * ITERS;
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   ws, wc;
  logic [QW-1:0]   qr, qmr;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    dfr;
  logic [QW-1:0]   quot_r;
  logic            remneg_r, sticky_r;

  logic            launch;
  logic            early_done;
  logic [WW-1:0]   ws4, wc4, dval, mag, term, cy, ws_nxt, wc_nxt, wsum;
  logic [7:0]      top;
  logic signed [6:0] est;
  logic signed [2:0] qdig;
  logic            pos;
  logic [1:0]      qm1;
  logic [QW-1:0]   q_src, qm_src, q_nxt, qm_nxt, q_fin, quot_c;
  logic            remneg_c, sticky_c;

  // Quotient digit selection from the divisor's top fraction bits and the residual estimate.
  function automatic logic signed [2:0] sel_digit(input logic [2:0] a, input logic signed [6:0] e);
    logic signed [6:0] t2, t1, t0, tm;
    case (a)
      3'd0:    begin t2 = 7'sd12; t1 = 7'sd4; t0 = -7'sd4; tm = -7'sd13; end
      3'd1:    begin t2 = 7'sd14; t1 = 7'sd4; t0 = -7'sd4; tm = -7'sd14; end
      3'd2:    begin t2 = 7'sd16; t1 = 7'sd4; t0 = -7'sd6; tm = -7'sd16; end
      3'd3:    begin t2 = 7'sd16; t1 = 7'sd4; t0 = -7'sd6; tm = -7'sd17; end
      3'd4:    begin t2 = 7'sd18; t1 = 7'sd6; t0 = -7'sd6; tm = -7'sd18; end
      3'd5:    begin t2 = 7'sd20; t1 = 7'sd6; t0 = -7'sd8; tm = -7'sd20; end
      3'd6:    begin t2 = 7'sd20; t1 = 7'sd8; t0 = -7'sd8; tm = -7'sd22; end
      default: begin t2 = 7'sd24; t1 = 7'sd8; t0 = -7'sd8; tm = -7'sd22; end
    endcase
    if (e >= t2)      return 3'sd2;
    else if (e >= t1) return 3'sd1;
    else if (e >= t0) return 3'sd0;
    else if (e >= tm) return -3'sd1;
    else              return -3'sd2;
  endfunction

  assign launch = (state == IDLE) && start && !abort;

  // One SRT step: estimate, digit select, CSA residual update, on-the-fly conversion, final sum.
  always_comb begin
    ws4  = ws << 2;
    wc4  = wc << 2;
    top  = ws4[WW-1 -: 8] + wc4[WW-1 -: 8];
    est  = 7'(top >> 1);
    qdig = sel_digit(dfr[N-1 -: 3], est);
    dval = {3'b000, 1'b1, dfr, 2'b00};
    // |q|==2 is 010/110, |q|==1 is 001/111.
    if (qdig[1] && !qdig[0]) mag = dval << 1;
    else if (qdig[0])        mag = dval;
    else                     mag = '0;
    // Positive digits subtract: one's complement here, +1 enters through wc[0].
    pos    = !qdig[2] && (qdig != 3'sd0);
    term   = pos ? ~mag : mag;
    ws_nxt = ws4 ^ wc4 ^ term;
    cy     = (ws4 & wc4) | (ws4 & term) | (wc4 & term);
    wc_nxt = (cy << 1) | WW'(pos);
    // Appended digits are q mod 4 and (q-1) mod 4 in every case.
    q_src  = qdig[2] ? qmr : qr;
    qm_src = pos ? qr : qmr;
    qm1    = qdig[1:0] - 2'd1;
    q_nxt  = (q_src << 2) | QW'(qdig[1:0]);
    qm_nxt = (qm_src << 2) | QW'(qm1);
    wsum     = ws + wc;
    remneg_c = wsum[WW-1];
    sticky_c = |wsum;
    quot_c   = remneg_c ? qmr : qr;
  end

`ifdef FDIVSQRT_R4_EARLYTERM_EN
  logic [WW-1:0] wnsum;
  logic [CW:0]   sh;
  // Exact quotient detected: stop early and left-align the digits produced so far.
  always_comb begin
    wnsum      = ws_nxt + wc_nxt;
    sh         = {LAST - cnt, 1'b0};
    early_done = (state == BUSY) && (wnsum == '0);
    q_fin      = early_done ? (q_nxt << sh) : q_nxt;
  end
`else
  assign early_done = 1'b0;
  assign q_fin      = q_nxt;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if ((cnt == LAST) || early_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Iteration registers: load on launch, step every non-aborted BUSY cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws  <= '0;
      wc  <= '0;
      qr  <= '0;
      qmr <= '0;
      cnt <= '0;
      dfr <= '0;
    end else if (launch) begin
      ws  <= {{(WW-N-1){1'b0}}, 1'b1, XFrac};
      wc  <= '0;
      qr  <= '0;
      qmr <= '0;
      cnt <= '0;
      dfr <= DFrac;
    end else if ((state == BUSY) && !abort) begin
      ws  <= ws_nxt;
      wc  <= wc_nxt;
      qr  <= q_fin;
      qmr <= qm_nxt;
      cnt <= cnt + CW'(1);
    end
  end

  // Result hold registers so outputs stay stable after the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quot_r   <= '0;
      remneg_r <= 1'b0;
      sticky_r <= 1'b0;
    end else if ((state == DONE) && !abort) begin
      quot_r   <= quot_c;
      remneg_r <= remneg_c;
      sticky_r <= sticky_c;
    end
  end

  // Outputs: live result during DONE, held result otherwise.
  always_comb begin
    ready  = (state == IDLE);
    done   = (state == DONE) && !abort;
    Quot   = (state == DONE) ? quot_c   : quot_r;
    RemNeg = (state == DONE) ? remneg_c : remneg_r;
    Sticky = (state == DONE) ? sticky_c : sticky_r;
  end

endmodule

// File: tb/tb_fdivsqrt_r4_iter.sv
module tb_fdivsqrt_r4_iter;
  localparam int N     = 52;
  localparam int ITERS = 28;
  localparam int QW    = 2 * ITERS;
  localparam int LAT   = ITERS + 1;
`ifdef FDIVSQRT_R4_EARLYTERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, start, abort;
  logic [N-1:0]  xfrac, dfrac;
  logic          ready, done, remneg, sticky;
  logic [QW-1:0] quot;

  typedef struct {
    logic [QW-1:0] q;
    logic          s;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fdivsqrt_r4_iter #(.N(N), .ITERS(ITERS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .XFrac(xfrac), .DFrac(dfrac), .ready(ready), .done(done),
    .Quot(quot), .RemNeg(remneg), .Sticky(sticky)
  );

  always #5 clk = ~clk;

  // Reference: floor(X/D * 2^(2*ITERS-2)) with exact integer division.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] d);
    logic [127:0] num, den, qq, rr;
    exp_t e;
    num = 128'({1'b1, x}) << (2 * ITERS - 2);
    den = 128'({1'b1, d});
    qq  = num / den;
    rr  = num % den;
    e.q = qq[QW-1:0];
    e.s = (rr != 0);
    return e;
  endfunction

  // Drive a one-cycle start at the current negedge; returns at the following negedge.
  task automatic go(input logic [N-1:0] x, input logic [N-1:0] d, input exp_t e);
    xfrac = x; dfrac = d; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges (1 = just before the first edge after the start edge) until done.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; xfrac = '0; dfrac = '0;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (quot !== '0) begin bad++; $display("FAIL reset_quot got=%h exp=0", quot); end
    total++; if (remneg !== 1'b0) begin bad++; $display("FAIL reset_remneg got=%b exp=0", remneg); end
    total++; if (sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b exp=0", sticky); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [N-1:0]  dx [3];
    logic [N-1:0]  dd [3];
    logic [QW-1:0] eq [3];
    logic          es [3];
    exp_t e, g;
    int lat;
    dx = '{52'h0, 52'h8_0000_0000_0000, 52'h0};
    dd = '{52'h0, 52'h0, 52'h8_0000_0000_0000};
    eq = '{56'h40_0000_0000_0000, 56'h60_0000_0000_0000, 56'h2A_AAAA_AAAA_AAAA};
    es = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      e.q = eq[i]; e.s = es[i];
      go(dx[i], dd[i], e);
      wait_done(lat);
      g = sb.pop_front();
      total++;
      if (!((ET && !g.s) ? (lat > 0 && lat < LAT) : (lat == LAT))) begin
        bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT);
      end
      total++; if (quot !== g.q) begin bad++; $display("FAIL dir%0d_quot got=%h exp=%h", i, quot, g.q); end
      total++; if (sticky !== g.s) begin bad++; $display("FAIL dir%0d_sticky got=%b exp=%b", i, sticky, g.s); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL dir%0d_ready_at_done got=%b exp=0", i, ready); end
      if (!g.s) begin
        total++; if (remneg !== 1'b0) begin bad++; $display("FAIL dir%0d_remneg got=%b exp=0", i, remneg); end
      end
      @(negedge clk);
      total++; if (quot !== g.q) begin bad++; $display("FAIL dir%0d_quot_hold got=%h exp=%h", i, quot, g.q); end
    end
  endtask

  task automatic test_random;
    logic [31:0] r1, r2, r3, r4;
    logic [N-1:0] x, d;
    exp_t g;
    int lat;
    for (int i = 0; i < 10; i++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
      x = {r1[19:0], r2};
      d = {r3[19:0], r4};
      if (i == 0) begin x = '1; d = '1; end
      if (i == 1) begin x = '0; d = '1; end
      if (i == 2) begin x = '1; d = '0; end
      go(x, d, model(x, d));
      wait_done(lat);
      g = sb.pop_front();
      total++;
      if (!((ET && !g.s) ? (lat > 0 && lat < LAT) : (lat == LAT))) begin
        bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, LAT);
      end
      total++; if (quot !== g.q) begin bad++; $display("FAIL rnd%0d_quot x=%h d=%h got=%h exp=%h", i, x, d, quot, g.q); end
      total++; if (sticky !== g.s) begin bad++; $display("FAIL rnd%0d_sticky got=%b exp=%b", i, sticky, g.s); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] x1, d1, x2, d2;
    exp_t g;
    int lat, busy_rdy_err;
    x1 = 52'h0; d1 = 52'h5_5555_5555_5555;
    x2 = 52'hF_FFFF_FFFF_FFFF; d2 = 52'h1_2345_6789_ABCD;
    xfrac = x1; dfrac = d1; start = 1'b1;
    sb.push_back(model(x1, d1));
    @(negedge clk);
    busy_rdy_err = 0;
    lat = 1;
    while (!done && lat < 100) begin
      if (ready !== 1'b0) busy_rdy_err++;
      xfrac = 52'(lat * 52'h3_1415_9265); dfrac = ~xfrac;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    g = sb.pop_front();
    total++; if (busy_rdy_err != 0) begin bad++; $display("FAIL b2b_ready_busy got=%0d_cycles_high exp=0", busy_rdy_err); end
    total++; if (lat != LAT) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (quot !== g.q) begin bad++; $display("FAIL b2b_first_quot got=%h exp=%h", quot, g.q); end
    total++; if (sticky !== g.s) begin bad++; $display("FAIL b2b_first_sticky got=%b exp=%b", sticky, g.s); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_done got=%b exp=0", ready); end
    // start still high; new operands land in the IDLE cycle right after done.
    xfrac = x2; dfrac = d2;
    sb.push_back(model(x2, d2));
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_idle got=%b exp=1", ready); end
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    g = sb.pop_front();
    total++; if (lat != LAT) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (quot !== g.q) begin bad++; $display("FAIL b2b_second_quot got=%h exp=%h", quot, g.q); end
    total++; if (sticky !== g.s) begin bad++; $display("FAIL b2b_second_sticky got=%b exp=%b", sticky, g.s); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    exp_t g;
    int lat, spurious;
    logic [N-1:0] x, d;
    x = 52'h3_0000_0000_0001; d = 52'hC_0000_0000_0000;
    go(x, d, model(x, d));
    repeat (9) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    void'(sb.pop_front());
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", ready); end
    spurious = 0;
    repeat (40) begin
      if (done !== 1'b0) spurious++;
      @(negedge clk);
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL abort_no_done got=%0d_pulses exp=0", spurious); end
    x = 52'h7_7777_7777_7777; d = 52'h2_2222_2222_2222;
    go(x, d, model(x, d));
    wait_done(lat);
    g = sb.pop_front();
    total++; if (lat != LAT) begin bad++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (quot !== g.q) begin bad++; $display("FAIL abort_next_quot got=%h exp=%h", quot, g.q); end
    total++; if (sticky !== g.s) begin bad++; $display("FAIL abort_next_sticky got=%b exp=%b", sticky, g.s); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t g;
    int lat, spurious;
    logic [N-1:0] x, d;
    x = 52'hA_BCDE_F012_3456; d = 52'h6_5432_1FED_CBA9;
    go(x, d, model(x, d));
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    void'(sb.pop_front());
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (quot !== '0) begin bad++; $display("FAIL rstmid_quot got=%h exp=0", quot); end
    total++; if (sticky !== 1'b0) begin bad++; $display("FAIL rstmid_sticky got=%b exp=0", sticky); end
    @(negedge clk);
    reset_n = 1'b1;
    spurious = 0;
    repeat (40) begin
      if (done !== 1'b0) spurious++;
      @(negedge clk);
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d_pulses exp=0", spurious); end
    x = 52'h8_0000_0000_0000; d = 52'h0;
    go(x, d, model(x, d));
    wait_done(lat);
    g = sb.pop_front();
    total++; if (quot !== g.q) begin bad++; $display("FAIL rstmid_next_quot got=%h exp=%h", quot, g.q); end
    total++; if (sticky !== g.s) begin bad++; $display("FAIL rstmid_next_sticky got=%b exp=%b", sticky, g.s); end
    total++; if (lat <= 0) begin bad++; $display("FAIL rstmid_next_timeout got=%0d exp=done", lat); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
